issue_select_arbiter: RTL and testbench
=======================================

Name: issue_select_arbiter

Overview:
- Per-FU select stage between the wakeup logic and execute.
- Each cycle it takes the reservation-station request vector and the target FU of every entry, and picks at most one entry per FU with a rotating-priority (round-robin) search.
- Grants are registered; they drive the wakeup-side grant_en/grant_index handshake and the FU issue ports.
- Tracks occupancy of non-pipelined FUs, for example a divider, so a busy unit is never granted.

Parameters:
- RS_ENTRIES, 16, reservation-station entries; power of two.
- NUM_FUS, 4, functional units.
- IDX_W, $clog2(RS_ENTRIES), entry index width.
- FU_W, $clog2(NUM_FUS), FU index width.
- FU_OCC, {8'd4,8'd1,8'd1,8'd1}, packed per-FU occupancy in cycles, FU0 in bits [7:0]; 1 = fully pipelined; legal range 1..255.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset; rst==0 at posedge resets the block.
- req_vector  in  RS_ENTRIES  entry j ready and not yet selected.
- entry_fu  in  RS_ENTRIES*FU_W  target FU of entry j, in bits [j*FU_W +: FU_W].
- fu_stall  in  NUM_FUS  FU f cannot accept a new op this cycle.
- flush  in  1  squash; kills decisions and occupancy.
- grant_en  out  NUM_FUS  registered grant valid per FU.
- grant_index  out  NUM_FUS*IDX_W  granted entry for FU f, in bits [f*IDX_W +: IDX_W].
- fu_busy  out  NUM_FUS  FU f occupancy counter nonzero.

Behaviour:
- Reset (rst==0 at posedge) clears all state:
  - grant_en=0, grant_index=0, fu_busy=0.
  - Occupancy counters occ_cnt[f]=0.
  - Priority pointers ptr[f]=0.
  - Inflight mask=0.
- Eligibility of entry j for FU f in cycle t:
  - req_vector[j]=1 and entry_fu[j]==f.
  - inflight[j]==0, where inflight = one-hot OR of the indices granted at the previous edge. This blocks a double grant while wakeup has not yet masked the entry.
- FU f may decide in cycle t only if occ_cnt[f]==0, fu_stall[f]==0 and flush==0.
- Selection order: the first eligible j scanning ptr[f], ptr[f]+1, … with wrap modulo RS_ENTRIES.
- Latency: a decision in cycle t appears on grant_en[f]/grant_index[f] for exactly one cycle at t+1.
- grant_en[f]=0 on cycles with no decision; grant_index holds its last value and is don't-care when grant_en=0.
- On a decision for entry k:
  - ptr[f] <= (k+1) mod RS_ENTRIES, wrapping 15->0 at default size.
  - occ_cnt[f] <= FU_OCC[f]-1.
- With no decision, ptr[f] is held.
- occ_cnt[f] decrements by 1 per cycle while nonzero, regardless of fu_stall.
- fu_busy[f] = (occ_cnt[f]!=0), registered.
- Resulting spacing: grants to FU f are at least FU_OCC[f] cycles apart; OCC=1 allows back-to-back grants.
- fu_stall[f] asserted in cycle t:
  - No decision for f in t.
  - A grant already registered at t is still presented; the stall does not retract it.
- Flush in cycle t:
  - No decisions in t, so grant_en=0 at t+1.
  - All occ_cnt cleared at t+1 and inflight cleared.
  - ptr retained.
- Independence: FUs arbitrate independently in the same cycle. An entry maps to one FU, so no entry is ever granted twice in a cycle.
- Empty request vector: no grants, no pointer movement.
- Reset mid-operation: pending grants are dropped and counters are cleared at the same edge.

Test Plan:
- Reset, req_vector=16'h0000 for 5 cycles -> grant_en=0, fu_busy=0 throughout, ptr all 0.
- Entries 3,7,12 on FU1 held requesting, wakeup clears entry one cycle after its grant -> grant_index[FU1] sequence 3,7,12 on consecutive cycles, ptr=13. Then entry 2 requests -> next grant 2 (wrap).
- Entry 5 on FU1 requesting in the cycle its grant is registered, with wakeup lag -> no second grant of 5 (inflight mask). Grant reappears only if 5 still requests two cycles later.
- Entries 0,1 on FU3 (OCC=4) from cycle 0 -> grant 0 at cycle 1, fu_busy[3]=1 cycles 1-3, grant 1 at cycle 5.
- Entry 4 on FU0 with fu_stall[0]=1 cycles 0-2 -> no grant until cycle 4. Entry 9 on FU2 in the same cycles -> granted at cycle 1, unaffected.
- FU3 busy (occ_cnt=2) and flush pulse with requests pending -> grant_en=0 the next cycle, fu_busy[3]=0 next cycle, normal grants resume the following cycle.

Source files
------------

// File: rtl/issue_select_arbiter.sv
// Per-FU round-robin select stage between wakeup and execute.
// Ports: clk, rst (sync active-low), req_vector, entry_fu, fu_stall,
//   flush in; grant_en, grant_index, fu_busy out.
module issue_select_arbiter #(
  parameter int RS_ENTRIES = 16,
  parameter int NUM_FUS    = 4,
  parameter int IDX_W      = $clog2(RS_ENTRIES),
  parameter int FU_W       = $clog2(NUM_FUS),
  parameter logic [NUM_FUS*8-1:0] FU_OCC =
    {8'd4, 8'd1, 8'd1, 8'd1}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [RS_ENTRIES-1:0]      req_vector,
  input  logic [RS_ENTRIES*FU_W-1:0] entry_fu,
  input  logic [NUM_FUS-1:0]         fu_stall,
  input  logic                       flush,
  output logic [NUM_FUS-1:0]         grant_en,
  output logic [NUM_FUS*IDX_W-1:0]   grant_index,
  output logic [NUM_FUS-1:0]         fu_busy
);

  logic [IDX_W-1:0]      ptr_q [NUM_FUS];
  logic [7:0]            occ_q [NUM_FUS];
  logic [RS_ENTRIES-1:0] inflight_q;

  logic [RS_ENTRIES-1:0] elig  [NUM_FUS];
  logic [IDX_W-1:0]      sel   [NUM_FUS];
  logic [NUM_FUS-1:0]    found;
  logic [NUM_FUS-1:0]    dec;
  logic [RS_ENTRIES-1:0] pick_mask;

  // Eligibility and rotating search starting at ptr_q[f].
  always_comb begin
    pick_mask = '0;
    for (int f = 0; f < NUM_FUS; f++) begin
      elig[f]  = '0;
      sel[f]   = '0;
      found[f] = 1'b0;
      for (int j = 0; j < RS_ENTRIES; j++) begin
        elig[f][j] = req_vector[j] &&
          (entry_fu[j*FU_W +: FU_W] == FU_W'(f)) &&
          !inflight_q[j];
      end
      for (int i = 0; i < RS_ENTRIES; i++) begin
        if (!found[f] &&
            elig[f][IDX_W'(ptr_q[f] + IDX_W'(i))]) begin
          found[f] = 1'b1;
          sel[f]   = IDX_W'(ptr_q[f] + IDX_W'(i));
        end
      end
      dec[f] = found[f] && (occ_q[f] == 8'd0) &&
               !fu_stall[f] && !flush;
      if (dec[f]) pick_mask[sel[f]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      grant_en    <= '0;
      grant_index <= '0;
      inflight_q  <= '0;
      for (int f = 0; f < NUM_FUS; f++) begin
        ptr_q[f] <= '0;
        occ_q[f] <= '0;
      end
    end else begin
      // Entries granted this edge stay masked one cycle
      // until wakeup drops their request.
      inflight_q <= pick_mask;
      grant_en   <= dec;
      for (int f = 0; f < NUM_FUS; f++) begin
        if (dec[f]) begin
          grant_index[f*IDX_W +: IDX_W] <= sel[f];
          ptr_q[f] <= IDX_W'(sel[f] + 1'b1);
          occ_q[f] <= FU_OCC[f*8 +: 8] - 8'd1;
        end else if (flush) begin
          occ_q[f] <= 8'd0;
        end else if (occ_q[f] != 8'd0) begin
          occ_q[f] <= occ_q[f] - 8'd1;
        end
      end
    end
  end

  always_comb begin
    for (int f = 0; f < NUM_FUS; f++)
      fu_busy[f] = (occ_q[f] != 8'd0);
  end

endmodule

// File: tb/tb_issue_select_arbiter.sv
// Testbench for issue_select_arbiter: behavioural model,
// directed scenarios with literal pins, then random traffic.
module tb_issue_select_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic [31:0] efu;
  logic [3:0]  stall;
  logic        flush;
  logic [3:0]  gen;
  logic [15:0] gidx;
  logic [3:0]  busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  issue_select_arbiter dut (
    .clk(clk), .rst(rst),
    .req_vector(req), .entry_fu(efu),
    .fu_stall(stall), .flush(flush),
    .grant_en(gen), .grant_index(gidx),
    .fu_busy(busy)
  );

  int occ_tbl [4] = '{1, 1, 1, 4};

  int m_ptr [4];
  int m_occ [4];
  int m_gidx [4];
  bit m_gen [4];
  bit m_infl [16];

  logic [15:0] prev_gm;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic set_fu(int j, int f);
    efu[j*2 +: 2] = 2'(f);
  endtask

  // One clock: evaluate the model on current inputs,
  // advance past the edge, compare every FU.
  task automatic step();
    bit nin [16];
    foreach (nin[j]) nin[j] = 1'b0;
    if (!rst) begin
      for (int f = 0; f < 4; f++) begin
        m_ptr[f] = 0; m_occ[f] = 0;
        m_gidx[f] = 0; m_gen[f] = 1'b0;
      end
    end else begin
      for (int f = 0; f < 4; f++) begin
        bit hit;
        int k;
        hit = 1'b0;
        k = 0;
        if (m_occ[f] == 0 && !stall[f] && !flush) begin
          for (int i = 0; i < 16; i++) begin
            int j;
            j = (m_ptr[f] + i) % 16;
            if (!hit && req[j] && !m_infl[j] &&
                int'(efu[j*2 +: 2]) == f) begin
              hit = 1'b1;
              k = j;
            end
          end
        end
        m_gen[f] = hit;
        if (hit) begin
          m_gidx[f] = k;
          m_ptr[f] = (k + 1) % 16;
          m_occ[f] = occ_tbl[f] - 1;
          nin[k] = 1'b1;
        end else if (flush) begin
          m_occ[f] = 0;
        end else if (m_occ[f] > 0) begin
          m_occ[f] = m_occ[f] - 1;
        end
      end
    end
    foreach (m_infl[j]) m_infl[j] = nin[j];
    @(posedge clk);
    #1;
    for (int f = 0; f < 4; f++) begin
      chk($sformatf("grant_en[%0d]", f),
          32'(gen[f]), 32'(m_gen[f]));
      if (m_gen[f])
        chk($sformatf("grant_index[%0d]", f),
            32'(gidx[f*4 +: 4]), 32'(m_gidx[f]));
      chk($sformatf("fu_busy[%0d]", f),
          32'(busy[f]), 32'(m_occ[f] != 0));
    end
  endtask

  // Wakeup lag: a granted entry drops its request
  // one cycle after the grant is seen.
  task automatic wake();
    logic [15:0] gm;
    gm = '0;
    for (int f = 0; f < 4; f++)
      if (m_gen[f]) gm[m_gidx[f]] = 1'b1;
    req = req & ~prev_gm;
    prev_gm = gm;
  endtask

  task automatic stepw();
    step();
    wake();
  endtask

  function automatic logic [3:0] gi(int f);
    return gidx[f*4 +: 4];
  endfunction

  initial begin
    rst = 1'b0; req = '0; efu = '0;
    stall = '0; flush = 1'b0; prev_gm = '0;
    foreach (m_infl[j]) m_infl[j] = 1'b0;

    repeat (5) step();
    chk("rst_grant_en", 32'(gen), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b1;
    repeat (2) step();

    // Round robin on FU1 with wakeup lag, then wrap.
    set_fu(3, 1); set_fu(7, 1); set_fu(12, 1);
    req = 16'h1088;
    stepw();
    chk("rr_g3", 32'(gi(1)), 3);
    stepw();
    chk("rr_g7", 32'(gi(1)), 7);
    stepw();
    chk("rr_g12", 32'(gi(1)), 12);
    stepw();
    chk("rr_idle", 32'(gen[1]), 0);
    stepw();
    chk("model_ptr13", 32'(m_ptr[1]), 13);
    set_fu(2, 1);
    req[2] = 1'b1;
    stepw();
    chk("rr_wrap_en", 32'(gen[1]), 1);
    chk("rr_wrap_g2", 32'(gi(1)), 2);
    repeat (2) stepw();

    // Inflight mask blocks a double grant of 5.
    req = '0; prev_gm = '0;
    set_fu(5, 1);
    req[5] = 1'b1;
    stepw();
    chk("infl_g5", 32'(gi(1)), 5);
    stepw();
    chk("infl_block", 32'(gen[1]), 0);
    req[5] = 1'b1;
    stepw();
    chk("infl_regrant", 32'(gen[1]), 1);
    chk("infl_regrant_5", 32'(gi(1)), 5);
    req = '0; prev_gm = '0;
    repeat (2) step();

    // FU3 occupancy of 4 cycles.
    set_fu(0, 3); set_fu(1, 3);
    req = 16'h0003;
    stepw();
    chk("occ_g0", 32'(gi(3)), 0);
    chk("occ_busy_c1", 32'(busy[3]), 1);
    stepw();
    chk("occ_busy_c2", 32'(busy[3]), 1);
    stepw();
    chk("occ_busy_c3", 32'(busy[3]), 1);
    stepw();
    chk("occ_busy_c4", 32'(busy[3]), 0);
    chk("occ_none_c4", 32'(gen[3]), 0);
    stepw();
    chk("occ_g1_en", 32'(gen[3]), 1);
    chk("occ_g1", 32'(gi(3)), 1);
    req = '0; prev_gm = '0;
    repeat (4) step();

    // Stall on FU0 does not disturb FU2.
    set_fu(4, 0); set_fu(9, 2);
    req = 16'h0210;
    stall = 4'b0001;
    stepw();
    chk("stall_fu2", 32'(gi(2)), 9);
    chk("stall_fu0_c1", 32'(gen[0]), 0);
    stepw();
    stepw();
    chk("stall_fu0_c3", 32'(gen[0]), 0);
    stall = '0;
    stepw();
    chk("stall_g4_en", 32'(gen[0]), 1);
    chk("stall_g4", 32'(gi(0)), 4);
    req = '0; prev_gm = '0;
    repeat (2) step();

    // Flush while FU3 busy.
    set_fu(6, 3); set_fu(8, 1); set_fu(10, 3);
    req = 16'h0040;
    stepw();
    stepw();
    chk("fl_busy_pre", 32'(busy[3]), 1);
    req = req | 16'h0500;
    flush = 1'b1;
    stepw();
    chk("fl_no_grant", 32'(gen), 0);
    chk("fl_busy_clr", 32'(busy[3]), 0);
    flush = 1'b0;
    stepw();
    chk("fl_g8", 32'(gi(1)), 8);
    chk("fl_g10", 32'(gi(3)), 10);
    chk("fl_resume", 32'(gen & 4'b1010), 32'(4'b1010));
    req = '0; prev_gm = '0;
    repeat (3) step();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      if (($urandom % 2) == 0) req = 16'($urandom);
      else req = 16'($urandom) & 16'($urandom);
      efu = $urandom;
      stall = (($urandom % 4) == 0) ? 4'($urandom) : 4'h0;
      flush = (($urandom % 20) == 0);
      rst = (($urandom % 150) != 0);
      step();
    end
    rst = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
